// File: rtl/chip_checker_led_pkg.sv
// Shared constants and the per-channel flash counter next-state helper
// for the chip checker LED driver.
package chip_checker_led_pkg;

  localparam int PWM_W         = 8;
  localparam int FLASH_W       = 4;
  localparam int DEFAULT_WIDTH = 14;

  localparam logic [PWM_W-1:0] PWM_FULL = '1;

  typedef enum logic [1:0] {
    FLASH_HOLD,
    FLASH_LOAD,
    FLASH_CLEAR,
    FLASH_DEC
  } flash_evt_e;

  // A rising edge outranks a period boundary, so a flash starting on a
  // wrap cycle keeps its full length.
  function automatic flash_evt_e flash_event(input logic rise, input logic fall,
                                             input logic period_start, input logic active);
    flash_evt_e evt;
    evt = FLASH_HOLD;
    if (rise)
      evt = FLASH_LOAD;
    else if (fall)
      evt = FLASH_CLEAR;
    else if (period_start && active)
      evt = FLASH_DEC;
    return evt;
  endfunction

  function automatic logic [FLASH_W-1:0] flash_next(input flash_evt_e evt,
                                                    input logic [FLASH_W-1:0] cnt,
                                                    input logic [FLASH_W-1:0] stretch);
    logic [FLASH_W-1:0] nxt;
    case (evt)
      FLASH_LOAD:  nxt = stretch;
      FLASH_CLEAR: nxt = '0;
      FLASH_DEC:   nxt = cnt - FLASH_W'(1);
      default:     nxt = cnt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/chip_checker_led_timebase.sv
// Shared PWM timebase: prescaler, 8-bit PWM counter, period-aligned
// brightness sample and blink phase generator.
module chip_checker_led_timebase
  import chip_checker_led_pkg::*;
#(
  parameter int PRESCALE    = 1000,
  parameter int BLINK_SHIFT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on,
  output logic             period_start,
  output logic             blink_phase
);

  localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE - 1);
  localparam int                BLINK_W = BLINK_SHIFT + 1;

  logic [PS_W-1:0]    prescaler;
  logic               tick;
  logic [PWM_W-1:0]   pwm_cnt;
  logic [PWM_W-1:0]   brightness_q;
  logic [BLINK_W-1:0] blink_cnt;

  assign tick         = (prescaler == PS_LAST);
  assign period_start = tick && (pwm_cnt == PWM_FULL);
  assign pwm_on       = (brightness_q == PWM_FULL) || (pwm_cnt < brightness_q);
  assign blink_phase  = blink_cnt[BLINK_SHIFT];

  // Brightness comes out of reset at full scale so LEDs show their level
  // immediately, and only moves on a period boundary to avoid torn duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler    <= '0;
      pwm_cnt      <= '0;
      brightness_q <= PWM_FULL;
      blink_cnt    <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      if (tick)
        pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (period_start) begin
        brightness_q <= brightness;
        blink_cnt    <= blink_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: rtl/chip_checker_led_driver.sv
// LED pin driver: synchronises the PIO levels, stretches rising edges into
// a visible flash, and otherwise applies global PWM dimming and blinking.
module chip_checker_led_driver
  import chip_checker_led_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PRESCALE    = 1000,
  parameter int STRETCH     = 4,
  parameter int BLINK_SHIFT = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] led_in,
  input  logic [PWM_W-1:0] brightness,
  input  logic [WIDTH-1:0] blink_mask,
  output logic [WIDTH-1:0] led_out,
  output logic             period_start
);

  localparam logic [FLASH_W-1:0] STRETCH_V = FLASH_W'(STRETCH);

  logic [WIDTH-1:0] led_q;
  logic             primed;
  logic             pwm_on;
  logic             blink_phase;

  chip_checker_led_timebase #(
    .PRESCALE    (PRESCALE),
    .BLINK_SHIFT (BLINK_SHIFT)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .brightness   (brightness),
    .pwm_on       (pwm_on),
    .period_start (period_start),
    .blink_phase  (blink_phase)
  );

  // The first capture after reset is the initial level, not an edge, so
  // LEDs already lit at reset release do not flash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q  <= '0;
      primed <= 1'b0;
    end else begin
      led_q  <= led_in;
      primed <= 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [FLASH_W-1:0] flash_cnt;
    logic               rise;
    logic               fall;
    logic               led_r;

    assign rise       = primed & led_in[i] & ~led_q[i];
    assign fall       = led_q[i] & ~led_in[i];
    assign led_out[i] = led_r;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        flash_cnt <= '0;
        led_r     <= 1'b0;
      end else begin
        flash_cnt <= flash_next(flash_event(rise, fall, period_start, flash_cnt != '0),
                                flash_cnt, STRETCH_V);
        led_r     <= led_q[i] & ((flash_cnt != '0) |
                                 (pwm_on & (~blink_mask[i] | blink_phase)));
      end
    end
  end

endmodule

// File: tb/tb_chip_checker_led_driver.sv
// Directed bench for chip_checker_led_driver with a time-based reference
// model (PRESCALE=1, STRETCH=2, BLINK_SHIFT=1).
module tb_chip_checker_led_driver;

  localparam int WIDTH       = 14;
  localparam int PRESCALE    = 1;
  localparam int STRETCH     = 2;
  localparam int BLINK_SHIFT = 1;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] led_in;
  logic [7:0]       brightness;
  logic [WIDTH-1:0] blink_mask;
  logic [WIDTH-1:0] led_out;
  logic             period_start;

  int checks = 0;
  int errors = 0;

  chip_checker_led_driver #(
    .WIDTH       (WIDTH),
    .PRESCALE    (PRESCALE),
    .STRETCH     (STRETCH),
    .BLINK_SHIFT (BLINK_SHIFT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .led_in       (led_in),
    .brightness   (brightness),
    .blink_mask   (blink_mask),
    .led_out      (led_out),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mn counts clock edges since reset release, so the PWM
  // position is mn%256, a period ends on mn%256==255 and the blink phase is
  // bit 0 of mn/512. A flash is kept as the edge number at which it expires.
  int               mn;
  int               bq;
  int               flash_end [WIDTH];
  logic [WIDTH-1:0] m_lq;
  logic [WIDTH-1:0] exp_led;

  function automatic int flash_expiry(input int e);
    int first_wrap;
    first_wrap = e + (255 - (e % 256));
    return first_wrap + 1 + 256 * (STRETCH - 1);
  endfunction

  function automatic bit model_pwm_on(input int n, input int b);
    return (b == 255) || ((n % 256) < b);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mn      = 0;
      bq      = 255;
      m_lq    = '0;
      exp_led = '0;
      for (int i = 0; i < WIDTH; i++) flash_end[i] = 0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        exp_led[i] = m_lq[i] && ((mn < flash_end[i]) ||
                     (model_pwm_on(mn, bq) && (!blink_mask[i] || ((mn / 512) % 2 == 1))));
      for (int i = 0; i < WIDTH; i++) begin
        if (led_in[i] && !m_lq[i] && mn >= 1) flash_end[i] = flash_expiry(mn + 1);
        else if (!led_in[i] && m_lq[i])       flash_end[i] = 0;
      end
      if ((mn + 1) % 256 == 0) bq = int'(brightness);
      m_lq = led_in;
      mn   = mn + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s n=%0d got %0h expected %0h", name, mn, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("model_led_out", 32'(led_out), 32'(exp_led));
    checkOutput("model_period_start", 32'(period_start), 32'((mn % 256) == 255));
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] li, input logic [7:0] br,
                               input logic [WIDTH-1:0] bm);
    led_in     = li;
    brightness = br;
    blink_mask = bm;
  endtask

  task automatic wait_n(input int target);
    while (mn < target) @(negedge clk);
  endtask

  task automatic count_high(input int idx, input int start_n, input int len,
                            output int hi, output int ps);
    wait_n(start_n);
    hi = 0;
    ps = 0;
    for (int k = 0; k < len; k++) begin
      if (led_out[idx]) hi++;
      if (period_start) ps++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog n=%0d got timeout expected finish", mn);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi;
    int ps;
    reset_n = 1'b0;
    applyStimulus(14'h3FFF, 8'd0, 14'h0000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("reset_before_edge", 32'(led_out), 32'h0);

    wait_n(1);   checkOutput("reset_n1", 32'(led_out), 32'h0);
    wait_n(2);   checkOutput("reset_n2", 32'(led_out), 32'h3FFF);
    wait_n(254); checkOutput("ps_n254", 32'(period_start), 32'h0);
    wait_n(255); checkOutput("ps_n255", 32'(period_start), 32'h1);
    wait_n(256); checkOutput("reset_n256", 32'(led_out), 32'h3FFF);
    wait_n(257); checkOutput("reset_n257", 32'(led_out), 32'h0);
    wait_n(300); checkOutput("reset_no_flash", 32'(led_out), 32'h0);

    wait_n(310);
    applyStimulus(14'h0001, 8'd64, 14'h0000);

    // Duty 64, with a switch to 200 at pwm position 100 of the same period.
    wait_n(513);
    hi = 0;
    ps = 0;
    for (int k = 0; k < 256; k++) begin
      if (mn == 612) brightness = 8'd200;
      if (led_out[0]) hi++;
      if (period_start) ps++;
      @(negedge clk);
    end
    checkOutput("duty64_high", 32'(hi), 32'd64);
    checkOutput("duty64_ps", 32'(ps), 32'd1);
    count_high(0, 769, 256, hi, ps);
    checkOutput("duty200_high", 32'(hi), 32'd200);
    checkOutput("duty200_ps", 32'(ps), 32'd1);

    wait_n(1030);
    applyStimulus(14'h0006, 8'd255, 14'h0004);
    count_high(2, 1537, 1024, hi, ps);
    checkOutput("blink_high", 32'(hi), 32'd512);
    wait_n(2600); checkOutput("blink_on", 32'(led_out), 32'h0006);
    wait_n(3100); checkOutput("blink_off", 32'(led_out), 32'h0002);

    wait_n(3110);
    applyStimulus(14'h0000, 8'd0, 14'h0000);
    wait_n(3400); led_in = 14'h0008;
    wait_n(3401); checkOutput("flash_n1", 32'(led_out[3]), 32'h0);
    count_high(3, 3402, 500, hi, ps);
    checkOutput("flash_len", 32'(hi), 32'd439);
    checkOutput("flash_ps", 32'(ps), 32'd2);

    wait_n(3910); led_in = 14'h0000;
    wait_n(3920); led_in = 14'h0008;
    wait_n(3922); checkOutput("flash2_on", 32'(led_out[3]), 32'h1);
    wait_n(3950); led_in = 14'h0000;
    wait_n(3951); checkOutput("fall_n1", 32'(led_out[3]), 32'h1);
    wait_n(3952); checkOutput("fall_n2", 32'(led_out[3]), 32'h0);

    wait_n(4095);
    checkOutput("coincide_ps", 32'(period_start), 32'h1);
    led_in = 14'h0020;
    count_high(5, 4096, 600, hi, ps);
    checkOutput("coincide_len", 32'(hi), 32'd512);
    checkOutput("coincide_ps_count", 32'(ps), 32'd2);

    wait_n(4700); led_in = 14'h0000;
    wait_n(4710); led_in = 14'h0020;
    wait_n(4800); checkOutput("preabort_flash", 32'(led_out), 32'h0020);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 32'(led_out), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_n(100); checkOutput("rereset_full_on", 32'(led_out), 32'h0020);
    wait_n(300); checkOutput("rereset_no_flash", 32'(led_out), 32'h0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
